// File: rtl/hack_cpu_ctrl_pkg.sv
// hack_cpu_ctrl_pkg
//   Shared definitions for the Hack CPU control core:
//   - controller state encoding
//   - instruction-register field positions (C-flag, a-bit, comp, dest, jump)
//   - dest/jump bit names and a small field-extraction helper
package hack_cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MREAD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MWRITE = 3'd4
    } state_t;

    // Instruction word layout (16-bit Hack encoding)
    localparam int CI_BIT  = 15;   // 1 = C-instruction
    localparam int IGN_HI  = 14;   // bits 14:13 carry no meaning
    localparam int IGN_LO  = 13;
    localparam int A_BIT   = 12;   // y operand: 0 = A, 1 = M
    localparam int COMP_HI = 11;   // {zx,nx,zy,ny,f,no}
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // Jump bit names inside the 3-bit jump field
    localparam int J_LT = 2;
    localparam int J_EQ = 1;
    localparam int J_GT = 0;

    function automatic logic [5:0] comp_field(input logic [15:0] ir);
        return ir[COMP_HI:COMP_LO];
    endfunction

endpackage

// File: rtl/hack_cpu_ctrl_jump_cond.sv
// hack_cpu_ctrl_jump_cond
//   Combinational jump decision from the instruction jump field and ALU flags.
// Ports:
//   j     in  3  jump field {lt, eq, gt}
//   zr    in  1  result is zero
//   ng    in  1  result is negative
//   take  out 1  branch to the target address
module hack_cpu_ctrl_jump_cond
    import hack_cpu_ctrl_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl
//   Multi-cycle control core of the 16-bit Hack CPU. Fetches and decodes
//   instructions, drives the external ALU (control bits and operands), writes
//   results to A/D/M and resolves jumps. Owns A, D and PC.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/addr/ack/data          instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/ack/rdata data access handshake (addr = A before the instruction)
//   alu_x, alu_y, alu_ctl           registered ALU operands and {zx,nx,zy,ny,f,no}
//   alu_out, alu_zr, alu_ng         combinational ALU result and flags
//   reg_a, reg_d                    A and D registers for observation
module hack_cpu_ctrl
    import hack_cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [5:0]        alu_ctl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_d
);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] addr_q;     // A as it was at decode: data address and jump target
    logic [5:0]        alu_ctl_q;
    logic [DATA_W-1:0] alu_x_q;
    logic [DATA_W-1:0] alu_y_q;    // A operand, or the M value latched by MREAD
    logic [DATA_W-1:0] r_q;
    logic              zr_q;
    logic              ng_q;
    logic              imem_req_q;
    logic              dmem_req_q;
    logic              dmem_we_q;

    logic [ADDR_W-1:0] pc_inc;
    logic              zr_sel;
    logic              ng_sel;
    logic              take;
    logic              unused_ir_bits;

    assign pc_inc = pc_q + ADDR_W'(1);

    // In EXEC the live ALU flags decide the jump; after an MWRITE the flags
    // latched in EXEC are used because the ALU inputs are no longer meaningful.
    assign zr_sel = (state == ST_EXEC) ? alu_zr : zr_q;
    assign ng_sel = (state == ST_EXEC) ? alu_ng : ng_q;

    hack_cpu_ctrl_jump_cond u_jump_cond (
        .j    (ir_q[JUMP_HI:JUMP_LO]),
        .zr   (zr_sel),
        .ng   (ng_sel),
        .take (take)
    );

    // imem_req_q resets high so the first fetch request appears in the first
    // cycle after reset release; gating with rst_n keeps every request low
    // while reset is held and drops it the instant reset is asserted.
    assign imem_req   = imem_req_q & rst_n;
    assign dmem_req   = dmem_req_q & rst_n;
    assign dmem_we    = dmem_we_q  & rst_n;
    assign imem_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = r_q;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_ctl    = alu_ctl_q;
    assign reg_a      = a_q;
    assign reg_d      = d_q;

    assign unused_ir_bits = ^ir_q[IGN_HI:IGN_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc_q       <= ADDR_W'(RESET_PC);
            a_q        <= '0;
            d_q        <= '0;
            ir_q       <= '0;
            addr_q     <= '0;
            alu_ctl_q  <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            r_q        <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_data;
                        imem_req_q <= 1'b0;
                        state      <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    // Capture operands and the pre-instruction A now, so later
                    // A writes cannot disturb the data address or jump target.
                    addr_q    <= a_q[ADDR_W-1:0];
                    alu_ctl_q <= comp_field(ir_q);
                    alu_x_q   <= d_q;
                    alu_y_q   <= a_q;
                    if (!ir_q[CI_BIT]) begin
                        a_q        <= ir_q;
                        pc_q       <= pc_inc;
                        imem_req_q <= 1'b1;
                        state      <= ST_FETCH;
                    end else if (ir_q[A_BIT]) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= 1'b0;
                        state      <= ST_MREAD;
                    end else begin
                        state <= ST_EXEC;
                    end
                end

                ST_MREAD: begin
                    if (dmem_ack) begin
                        alu_y_q    <= dmem_rdata;
                        dmem_req_q <= 1'b0;
                        state      <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_q  <= alu_out;
                    zr_q <= alu_zr;
                    ng_q <= alu_ng;
                    if (ir_q[DEST_D]) d_q <= alu_out;
                    if (ir_q[DEST_A]) a_q <= alu_out;
                    if (ir_q[DEST_M]) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= 1'b1;
                        state      <= ST_MWRITE;
                    end else begin
                        pc_q       <= take ? addr_q : pc_inc;
                        imem_req_q <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end

                ST_MWRITE: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        pc_q       <= take ? addr_q : pc_inc;
                        imem_req_q <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end

                default: begin
                    state      <= ST_FETCH;
                    imem_req_q <= 1'b1;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl
//   Testbench for hack_cpu_ctrl: memory responders with configurable wait
//   states, a bit-level Hack ALU as environment, directed scenarios and a
//   randomized program checked against an instruction-level reference model.
module tb_hack_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] reg_a;
    logic [15:0] reg_d;

    int checks = 0;
    int errors = 0;

    hack_cpu_ctrl #(.ADDR_W(15), .DATA_W(16), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctl    (alu_ctl),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .reg_a      (reg_a),
        .reg_d      (reg_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: the generic Hack ALU driven by the six control bits
    logic [15:0] ax0, ax, ay0, ay, af;
    assign ax0     = alu_ctl[5] ? 16'h0000 : alu_x;
    assign ax      = alu_ctl[4] ? ~ax0 : ax0;
    assign ay0     = alu_ctl[3] ? 16'h0000 : alu_y;
    assign ay      = alu_ctl[2] ? ~ay0 : ay0;
    assign af      = alu_ctl[1] ? (ax + ay) : (ax & ay);
    assign alu_out = alu_ctl[0] ? ~af : af;
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    // Memories and responder state
    logic [15:0] imem  [0:32767];
    logic [15:0] dmem  [0:32767];
    logic [15:0] m_mem [0:32767];
    int imem_wait = 0;
    int dmem_wait = 0;
    int icnt = 0;
    int dcnt = 0;
    logic [30:0] act_q[$];
    logic [30:0] exp_q[$];

    // The 18 Hack comp mnemonics, used to build random C-instructions
    logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                               6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                               6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                               6'b000111, 6'b000000, 6'b010101};

    // Memory responders: decide ack for the coming rising edge at each falling edge
    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_data = 16'h0; dmem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (icnt >= imem_wait) begin
                    imem_ack = 1'b1; imem_data = imem[imem_addr]; icnt = 0;
                end else begin
                    imem_ack = 1'b0; icnt++;
                end
            end else begin
                imem_ack = 1'b0; icnt = 0;
            end
            if (dmem_req) begin
                if (dcnt >= dmem_wait) begin
                    dmem_ack = 1'b1; dcnt = 0;
                    if (dmem_we) begin
                        dmem[dmem_addr] = dmem_wdata;
                        act_q.push_back({dmem_addr, dmem_wdata});
                    end else begin
                        dmem_rdata = dmem[dmem_addr];
                    end
                end else begin
                    dmem_ack = 1'b0; dcnt++;
                end
            end else begin
                dmem_ack = 1'b0; dcnt = 0;
            end
        end
    end

    // Reference semantics of the Hack comp mnemonics
    function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    function automatic logic [15:0] gen_instr();
        logic [5:0] c;
        if ($urandom_range(0, 9) < 4) return {1'b0, 15'($urandom)};
        c = comps[$urandom_range(0, 17)];
        return {1'b1, 2'($urandom), 1'($urandom), c, 3'($urandom), 3'($urandom)};
    endfunction

    task automatic hold_reset();
        rst_n = 1'b0;
        act_q.delete();
        exp_q.delete();
        @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait (bounded) for a fetch acknowledge; cyc = falling edges counted, ack edge included
    task automatic wait_fetch(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk); #1; cyc++;
        end while (!(imem_req && imem_ack) && cyc < 500);
        if (!(imem_req && imem_ack)) begin
            checks++; errors++;
            $display("FAIL fetch_timeout no fetch ack after %0d cycles", cyc);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        hold_reset();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %b exp 0", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req got %b exp 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_dmem_we got %b exp 0", dmem_we); end
        checks++; if (imem_addr !== 15'h0000) begin errors++; $display("FAIL rst_pc got %h exp 0000", imem_addr); end
        checks++; if (reg_a !== 16'h0 || reg_d !== 16'h0) begin errors++; $display("FAIL rst_ad got A=%h D=%h exp 0", reg_a, reg_d); end
    endtask

    task automatic test_a_instr();
        hold_reset();
        imem_wait = 0; dmem_wait = 0;
        imem[0] = 16'h0005; imem[1] = 16'h0000;
        release_reset();
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 15'd0) begin errors++; $display("FAIL t1_first_req got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t1_decode_req got %b exp 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 15'd1) begin errors++; $display("FAIL t1_second_fetch got req=%b addr=%h exp 1/0001", imem_req, imem_addr); end
        checks++; if (reg_a !== 16'h0005) begin errors++; $display("FAIL t1_reg_a got %h exp 0005", reg_a); end
    endtask

    task automatic test_c_instr();
        int cyc;
        hold_reset();
        imem_wait = 0; dmem_wait = 0;
        imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0000;
        release_reset();
        wait_fetch(cyc);
        wait_fetch(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL t2_a_latency got %0d exp 2", cyc); end
        step();
        step();
        checks++; if (alu_ctl !== 6'b110000) begin errors++; $display("FAIL t2_alu_ctl got %b exp 110000", alu_ctl); end
        checks++; if (alu_y !== 16'h0005) begin errors++; $display("FAIL t2_alu_y got %h exp 0005", alu_y); end
        wait_fetch(cyc);
        checks++; if (cyc !== 1 || imem_addr !== 15'd2) begin errors++; $display("FAIL t2_c_latency got %0d/%h exp 1/0002", cyc, imem_addr); end
        checks++; if (reg_d !== 16'h0005) begin errors++; $display("FAIL t2_reg_d got %h exp 0005", reg_d); end
    endtask

    task automatic test_mwrite_wait();
        int cyc;
        hold_reset();
        imem_wait = 0; dmem_wait = 3;
        imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0007; imem[3] = 16'hE7C8; imem[4] = 16'h0000;
        dmem[7] = 16'h0000;
        release_reset();
        for (int i = 0; i < 4; i++) wait_fetch(cyc);
        step();
        step();
        checks++; if (alu_ctl !== 6'b011111 || alu_x !== 16'h0005 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL t3_exec got ctl=%b x=%h dreq=%b exp 011111/0005/0", alu_ctl, alu_x, dmem_req);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'd7 || dmem_wdata !== 16'h0006 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL t3_mwrite_hold cyc%0d got req=%b we=%b addr=%h wdata=%h ireq=%b exp 1/1/0007/0006/0",
                         i, dmem_req, dmem_we, dmem_addr, dmem_wdata, imem_req);
            end
        end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 15'd4 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL t3_after_ack got ireq=%b pc=%h dreq=%b exp 1/0004/0", imem_req, imem_addr, dmem_req);
        end
        checks++; if (dmem[7] !== 16'h0006) begin errors++; $display("FAIL t3_mem got %h exp 0006", dmem[7]); end
        dmem_wait = 0;
    endtask

    task automatic test_mread();
        int cyc;
        hold_reset();
        imem_wait = 0; dmem_wait = 0;
        imem[0] = 16'h0003; imem[1] = 16'hFC10; imem[2] = 16'h0000;
        dmem[3] = 16'h00FF;
        release_reset();
        wait_fetch(cyc);
        wait_fetch(cyc);
        step();
        step();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 15'd3) begin
            errors++; $display("FAIL t4_mread got req=%b we=%b addr=%h exp 1/0/0003", dmem_req, dmem_we, dmem_addr);
        end
        step();
        checks++; if (alu_y !== 16'h00FF) begin errors++; $display("FAIL t4_alu_y got %h exp 00ff", alu_y); end
        wait_fetch(cyc);
        checks++; if (reg_d !== 16'h00FF || imem_addr !== 15'd2 || cyc !== 1) begin
            errors++; $display("FAIL t4_result got D=%h pc=%h cyc=%0d exp 00ff/0002/1", reg_d, imem_addr, cyc);
        end
    endtask

    task automatic test_jump();
        int cyc;
        hold_reset();
        imem_wait = 0; dmem_wait = 0;
        imem[0] = 16'h0000; imem[1] = 16'hEC10; imem[2] = 16'h000A; imem[3] = 16'hEA82;
        imem[10] = 16'hEA87; imem[11] = 16'hEA87; imem[15'h7FFF] = 16'hEA80;
        release_reset();
        for (int i = 0; i < 5; i++) wait_fetch(cyc);
        checks++; if (imem_addr !== 15'd10) begin errors++; $display("FAIL t5_jeq got %h exp 000a", imem_addr); end
        imem[10] = 16'h7FFF;
        wait_fetch(cyc);
        checks++; if (imem_addr !== 15'd10) begin errors++; $display("FAIL t5_jmp got %h exp 000a", imem_addr); end
        wait_fetch(cyc);
        wait_fetch(cyc);
        checks++; if (imem_addr !== 15'h7FFF) begin errors++; $display("FAIL t5_to_top got %h exp 7fff", imem_addr); end
        wait_fetch(cyc);
        checks++; if (imem_addr !== 15'h0000 || reg_a !== 16'h7FFF) begin
            errors++; $display("FAIL t5_wrap got pc=%h A=%h exp 0000/7fff", imem_addr, reg_a);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        hold_reset();
        imem_wait = 0; dmem_wait = 20;
        imem[0] = 16'h0009; imem[1] = 16'hEC10; imem[2] = 16'h0007; imem[3] = 16'hE7C8;
        release_reset();
        for (int i = 0; i < 4; i++) wait_fetch(cyc);
        step(); step(); step();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL t6_in_mwrite got req=%b we=%b exp 1/1", dmem_req, dmem_we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL t6_req_drop got dreq=%b we=%b ireq=%b exp 0/0/0", dmem_req, dmem_we, imem_req);
        end
        checks++; if (imem_addr !== 15'd0 || reg_a !== 16'h0 || reg_d !== 16'h0) begin
            errors++; $display("FAIL t6_regs got pc=%h A=%h D=%h exp 0", imem_addr, reg_a, reg_d);
        end
        @(posedge clk);
        dmem_wait = 0;
        act_q.delete();
        release_reset();
        wait_fetch(cyc);
        checks++; if (imem_addr !== 15'd0 || cyc !== 1) begin errors++; $display("FAIL t6_restart got pc=%h cyc=%0d exp 0000/1", imem_addr, cyc); end
    endtask

    task automatic test_random();
        int cyc, exp_cyc, iw, dw;
        logic [14:0] m_pc;
        logic [15:0] m_a, m_d, ins, olda, r;
        logic signed [15:0] rs;
        logic jmp;
        hold_reset();
        imem_wait = 0; dmem_wait = 0;
        for (int i = 0; i < 32768; i++) begin
            imem[i] = gen_instr();
            dmem[i] = 16'($urandom);
            m_mem[i] = dmem[i];
        end
        m_pc = 15'd0; m_a = 16'd0; m_d = 16'd0; exp_cyc = 0;
        release_reset();
        for (int n = 0; n < 400; n++) begin
            wait_fetch(cyc);
            checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, imem_addr, m_pc); end
            checks++; if (reg_a !== m_a) begin errors++; $display("FAIL rnd_a n=%0d got %h exp %h", n, reg_a, m_a); end
            checks++; if (reg_d !== m_d) begin errors++; $display("FAIL rnd_d n=%0d got %h exp %h", n, reg_d, m_d); end
            if (n > 0) begin
                checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rnd_latency n=%0d got %0d exp %0d", n, cyc, exp_cyc); end
            end
            checks++;
            if (act_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rnd_wr_count n=%0d got %0d exp %0d", n, act_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++)
                    if (act_q[k] !== exp_q[k]) begin
                        errors++; $display("FAIL rnd_wr n=%0d got %h exp %h", n, act_q[k], exp_q[k]);
                    end
            end
            act_q.delete();
            exp_q.delete();
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            imem_wait = iw;
            dmem_wait = dw;
            ins = imem[m_pc];
            if (!ins[15]) begin
                m_a = ins;
                m_pc = m_pc + 15'd1;
                exp_cyc = 2 + iw;
            end else begin
                olda = m_a;
                r = ref_comp(ins[11:6], m_d, ins[12] ? m_mem[olda[14:0]] : m_a);
                exp_cyc = 3 + iw;
                if (ins[12]) exp_cyc += 1 + dw;
                if (ins[3]) begin
                    m_mem[olda[14:0]] = r;
                    exp_q.push_back({olda[14:0], r});
                    exp_cyc += 1 + dw;
                end
                if (ins[4]) m_d = r;
                if (ins[5]) m_a = r;
                rs = r;
                jmp = (ins[2] && rs < 0) || (ins[1] && rs == 0) || (ins[0] && rs > 0);
                m_pc = jmp ? olda[14:0] : m_pc + 15'd1;
            end
        end
        imem_wait = 0;
        dmem_wait = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_a_instr();
        test_c_instr();
        test_mwrite_wait();
        test_mread();
        test_jump();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
